// File: rtl/mznm_pkg.sv
// Shared fetch types and constants.
// Imported by fetch_stage and fetch_ifid_reg.
package mznm_pkg;

  typedef enum logic [1:0] {
    S_OP  = 2'd0,
    S_IMM = 2'd1,
    S_INT = 2'd2
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam int          EXT_BIT   = 15;
  localparam logic [1:0]  INT_ENTRY = 2'b11;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  localparam if_id_t IFID_BUBBLE = '{
    instr: NOP_INSTR,
    imm:   16'h0000,
    pc:    32'h0,
    valid: 1'b0
  };

  // Opcode words with the top bit set carry an immediate word.
  function automatic logic is_ext(
    input logic [15:0] w
  );
    return w[EXT_BIT];
  endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register.
// Clear beats hold; hold is simply load deasserted.
module fetch_ifid_reg
  import mznm_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= IFID_BUBBLE;
    end else if (clear) begin
      q <= IFID_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: assembles 1- or 2-word instructions into IF/ID.
// Interrupt entry is built only when FETCH_INTERRUPT_EN is defined.
module fetch_stage
  import mznm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [15:0] imemData,
  input  logic        stall,
  input  logic        flush,
  input  logic        interruptReq,
  output logic [15:0] fetchInstr,
  output logic [15:0] fetchImm,
  output logic [31:0] fetchPc,
  output logic        fetchValid,
  output logic [1:0]  interruptSignal,
  output logic [31:0] savedPc
);

  fetch_state_e state;
  fetch_state_e state_n;

  logic [15:0] hold_instr;
  logic [15:0] hold_instr_n;
  logic [31:0] hold_pc;
  logic [31:0] hold_pc_n;

  logic   int_pending;
  if_id_t ifid_d;
  if_id_t ifid_q;

  always_comb begin
    state_n      = state;
    hold_instr_n = hold_instr;
    hold_pc_n    = hold_pc;
    ifid_d       = IFID_BUBBLE;
    unique case (1'b1)
      (state == S_OP): begin
        if (int_pending) begin
          state_n = S_INT;
        end else if (is_ext(imemData)) begin
          hold_instr_n = imemData;
          hold_pc_n    = pc;
          state_n      = S_IMM;
        end else begin
          ifid_d = '{
            instr: imemData,
            imm:   16'h0000,
            pc:    pc,
            valid: 1'b1
          };
        end
      end
      (state == S_IMM): begin
        ifid_d = '{
          instr: hold_instr,
          imm:   imemData,
          pc:    hold_pc,
          valid: 1'b1
        };
        state_n = S_OP;
      end
      default: begin
        state_n = S_OP;
      end
    endcase
  end

  // A flush abandons any half-fetched instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_OP;
      hold_instr <= NOP_INSTR;
      hold_pc    <= 32'h0;
    end else if (flush) begin
      state <= S_OP;
    end else if (!stall) begin
      state      <= state_n;
      hold_instr <= hold_instr_n;
      hold_pc    <= hold_pc_n;
    end
  end

  fetch_ifid_reg u_ifid (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .load  (!stall),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign fetchInstr = ifid_q.instr;
  assign fetchImm   = ifid_q.imm;
  assign fetchPc    = ifid_q.pc;
  assign fetchValid = ifid_q.valid;

`ifdef FETCH_INTERRUPT_EN
  logic        pending;
  logic        entry;
  logic [31:0] saved_pc;

  assign entry = (state == S_OP) && pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      saved_pc <= 32'h0;
    end else if (flush) begin
      pending <= pending | interruptReq;
    end else if (!stall) begin
      pending <= (pending & ~entry) | interruptReq;
      if (entry) begin
        saved_pc <= pc;
      end
    end
  end

  assign int_pending     = pending;
  assign savedPc         = saved_pc;
  assign interruptSignal =
    (state == S_INT) ? INT_ENTRY : 2'b00;
`else
  logic unused_irq;

  assign unused_irq      = interruptReq;
  assign int_pending     = 1'b0;
  assign savedPc         = 32'h0;
  assign interruptSignal = 2'b00;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Interrupt scenario follows FETCH_INTERRUPT_EN.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [15:0] imemData;
  logic        stall;
  logic        flush;
  logic        interruptReq;
  logic [15:0] fetchInstr;
  logic [15:0] fetchImm;
  logic [31:0] fetchPc;
  logic        fetchValid;
  logic [1:0]  interruptSignal;
  logic [31:0] savedPc;

  int tests;
  int fails;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .imemData        (imemData),
    .stall           (stall),
    .flush           (flush),
    .interruptReq    (interruptReq),
    .fetchInstr      (fetchInstr),
    .fetchImm        (fetchImm),
    .fetchPc         (fetchPc),
    .fetchValid      (fetchValid),
    .interruptSignal (interruptSignal),
    .savedPc         (savedPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    pc           = 32'h0;
    imemData     = 16'h0;
    stall        = 1'b0;
    flush        = 1'b0;
    interruptReq = 1'b0;
    @(negedge clk);
    tests++;
    if ({fetchInstr, fetchImm, fetchPc, fetchValid} !== 65'h0) begin
      fails++;
      $display("FAIL reset_ifid got %h/%h/%h/%b want 0",
               fetchInstr, fetchImm, fetchPc, fetchValid);
    end
    tests++;
    if (interruptSignal !== 2'b00 || savedPc !== 32'h0) begin
      fails++;
      $display("FAIL reset_int got sig=%b saved=%h want 0",
               interruptSignal, savedPc);
    end
    reset = 1'b0;
  endtask

  task automatic test_short();
    pc       = 32'd32;
    imemData = 16'h1234;
    tick();
    tests++;
    if (fetchInstr !== 16'h1234 || fetchImm !== 16'h0 ||
        fetchPc !== 32'd32 || fetchValid !== 1'b1) begin
      fails++;
      $display("FAIL short got %h/%h/%0d/%b want 1234/0000/32/1",
               fetchInstr, fetchImm, fetchPc, fetchValid);
    end
    // stall holds a valid instruction in IF/ID
    stall    = 1'b1;
    pc       = 32'd99;
    imemData = 16'h0abc;
    tick();
    tests++;
    if (fetchInstr !== 16'h1234 || fetchPc !== 32'd32 ||
        fetchValid !== 1'b1) begin
      fails++;
      $display("FAIL short_hold got %h/%0d/%b want 1234/32/1",
               fetchInstr, fetchPc, fetchValid);
    end
    stall = 1'b0;
  endtask

  task automatic test_ext();
    pc       = 32'd33;
    imemData = 16'h8001;
    tick();
    tests++;
    if (fetchValid !== 1'b0) begin
      fails++;
      $display("FAIL ext_first got valid=%b want 0", fetchValid);
    end
    pc       = 32'd34;
    imemData = 16'h00ff;
    tick();
    tests++;
    if (fetchInstr !== 16'h8001 || fetchImm !== 16'h00ff ||
        fetchPc !== 32'd33 || fetchValid !== 1'b1) begin
      fails++;
      $display("FAIL ext got %h/%h/%0d/%b want 8001/00ff/33/1",
               fetchInstr, fetchImm, fetchPc, fetchValid);
    end
  endtask

  task automatic test_stall();
    pc       = 32'd50;
    imemData = 16'h8123;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc       = 32'd200 + i;
      imemData = 16'h0f00 + 16'(i);
      tick();
      tests++;
      if (fetchValid !== 1'b0 || fetchInstr !== 16'h0) begin
        fails++;
        $display("FAIL stall_%0d got %h/%b want 0000/0",
                 i, fetchInstr, fetchValid);
      end
    end
    stall    = 1'b0;
    pc       = 32'd51;
    imemData = 16'h0077;
    tick();
    tests++;
    if (fetchInstr !== 16'h8123 || fetchImm !== 16'h0077 ||
        fetchPc !== 32'd50 || fetchValid !== 1'b1) begin
      fails++;
      $display("FAIL stall_done got %h/%h/%0d/%b want 8123/0077/50/1",
               fetchInstr, fetchImm, fetchPc, fetchValid);
    end
  endtask

  task automatic test_flush();
    pc       = 32'd60;
    imemData = 16'h8aaa;
    tick();
    flush    = 1'b1;
    stall    = 1'b1;
    pc       = 32'd61;
    imemData = 16'h0042;
    tick();
    tests++;
    if (fetchValid !== 1'b0 || fetchInstr !== 16'h0 ||
        fetchImm !== 16'h0) begin
      fails++;
      $display("FAIL flush got %h/%h/%b want 0000/0000/0",
               fetchInstr, fetchImm, fetchValid);
    end
    flush = 1'b0;
    stall = 1'b0;
    tick();
    tests++;
    if (fetchInstr !== 16'h0042 || fetchImm !== 16'h0 ||
        fetchPc !== 32'd61 || fetchValid !== 1'b1) begin
      fails++;
      $display("FAIL flush_next got %h/%h/%0d/%b want 0042/0000/61/1",
               fetchInstr, fetchImm, fetchPc, fetchValid);
    end
  endtask

  task automatic test_interrupt();
    pc       = 32'd39;
    imemData = 16'h8005;
    tick();
    pc           = 32'd40;
    imemData     = 16'h0011;
    interruptReq = 1'b1;
    tick();
    interruptReq = 1'b0;
    tests++;
    if (fetchInstr !== 16'h8005 || fetchImm !== 16'h0011 ||
        fetchPc !== 32'd39 || fetchValid !== 1'b1 ||
        interruptSignal !== 2'b00) begin
      fails++;
      $display("FAIL irq_complete got %h/%h/%0d/%b sig=%b",
               fetchInstr, fetchImm, fetchPc, fetchValid,
               interruptSignal);
    end
    pc       = 32'd41;
    imemData = 16'h1111;
    tick();
`ifdef FETCH_INTERRUPT_EN
    tests++;
    if (fetchValid !== 1'b0 || savedPc !== 32'd41 ||
        interruptSignal !== 2'b11) begin
      fails++;
      $display("FAIL irq_entry got v=%b saved=%0d sig=%b want 0/41/11",
               fetchValid, savedPc, interruptSignal);
    end
    pc       = 32'd0;
    imemData = 16'h2222;
    tick();
    tests++;
    if (fetchValid !== 1'b0 || interruptSignal !== 2'b00) begin
      fails++;
      $display("FAIL irq_return got v=%b sig=%b want 0/00",
               fetchValid, interruptSignal);
    end
    tick();
    tests++;
    if (fetchInstr !== 16'h2222 || fetchPc !== 32'd0 ||
        fetchValid !== 1'b1 || savedPc !== 32'd41) begin
      fails++;
      $display("FAIL irq_resume got %h/%0d/%b saved=%0d",
               fetchInstr, fetchPc, fetchValid, savedPc);
    end
`else
    tests++;
    if (fetchInstr !== 16'h1111 || fetchPc !== 32'd41 ||
        fetchValid !== 1'b1 || savedPc !== 32'h0 ||
        interruptSignal !== 2'b00) begin
      fails++;
      $display("FAIL irq_ignored got %h/%0d/%b saved=%h sig=%b",
               fetchInstr, fetchPc, fetchValid, savedPc,
               interruptSignal);
    end
`endif
  endtask

  task automatic test_reset_mid();
    pc       = 32'd69;
    imemData = 16'h0555;
    tick();
    tests++;
    if (fetchInstr !== 16'h0555 || fetchValid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset got %h/%b want 0555/1",
               fetchInstr, fetchValid);
    end
    pc       = 32'd70;
    imemData = 16'h8bbb;
    tick();
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({fetchInstr, fetchImm, fetchPc, fetchValid} !== 65'h0 ||
        interruptSignal !== 2'b00 || savedPc !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid got %h/%h/%h/%b sig=%b saved=%h",
               fetchInstr, fetchImm, fetchPc, fetchValid,
               interruptSignal, savedPc);
    end
    @(negedge clk);
    reset    = 1'b0;
    pc       = 32'd71;
    imemData = 16'h0033;
    tick();
    tests++;
    if (fetchInstr !== 16'h0033 || fetchImm !== 16'h0 ||
        fetchPc !== 32'd71 || fetchValid !== 1'b1) begin
      fails++;
      $display("FAIL reset_resume got %h/%h/%0d/%b want 0033/0000/71/1",
               fetchInstr, fetchImm, fetchPc, fetchValid);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_short();
    test_ext();
    test_stall();
    test_flush();
    test_interrupt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
